// File: rtl/mips_memory_stage_pipe.sv
// mips_memory_stage_pipe: pipelined MIPS load/store stage over a 1-cycle synchronous RAM.
// Define MIPS_MEMORY_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of forcing alignment.
module mips_memory_stage_pipe #(
    parameter int ADDR_L = 64,
    parameter int ADDR_W = $clog2(ADDR_L),
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_is_load,
    output logic              out_fault
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [ADDR_L];
    logic [DATA_W-1:0] rdData, wrData;
    logic [LANES-1:0]  wrEn;
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        size, off, offReg, sizeReg;
    logic              accept, isStore, illegal, misaligned, fault, unsReg;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic              unusedAddr;

    assign in_ready   = ~out_valid | out_ready;
    assign accept     = in_valid & in_ready;
    assign isStore    = in_op[3];
    assign size       = in_op[2:1];
    assign wordIdx    = in_addr[ADDR_W+1:2];
    assign unusedAddr = ^in_addr[31:ADDR_W+2];
    assign illegal    = size == 2'b11;
    assign misaligned = (size == 2'b01 & in_addr[0]) | (size == 2'b10 & |in_addr[1:0]);
`ifdef MIPS_MEMORY_MISALIGN_TRAP_EN
    assign fault = illegal | misaligned;
`else
    assign fault = illegal;
`endif
    // Offset forced to alignment; in the trap build misaligned ops never reach the RAM anyway.
    assign off = size == 2'b01 ? {in_addr[1], 1'b0} : size == 2'b10 ? 2'b00 : in_addr[1:0];

    assign wrData = size == 2'b00 ? {LANES{in_data[7:0]}} :
                    size == 2'b01 ? {(LANES/2){in_data[15:0]}} : {(LANES/4){in_data[31:0]}};
    assign wrEn   = size == 2'b00 ? LANES'(1) << off :
                    size == 2'b01 ? LANES'(3) << off : {LANES{1'b1}};

    always_ff @(posedge clock) begin
        if (accept & isStore & ~fault)
            for (int i = 0; i < LANES; i++)
                if (wrEn[i]) mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
        if (accept & ~isStore & ~fault)
            rdData <= mem[wordIdx];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_is_load <= 1'b0;
            out_fault   <= 1'b0;
            offReg      <= '0;
            sizeReg     <= '0;
            unsReg      <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_rd      <= in_rd;
                out_is_load <= ~isStore & ~fault;
                out_fault   <= fault;
                offReg      <= off;
                sizeReg     <= size;
                unsReg      <= in_op[0];
            end
        end
    end

    assign loadByte = rdData[8*offReg +: 8];
    assign loadHalf = rdData[16*offReg[1] +: 16];
    assign out_data = ~out_is_load ? '0 :
                      sizeReg == 2'b00 ? {{(DATA_W-8){~unsReg & loadByte[7]}}, loadByte} :
                      sizeReg == 2'b01 ? {{(DATA_W-16){~unsReg & loadHalf[15]}}, loadHalf} : rdData;
endmodule

// File: tb/tb_mips_memory_stage_pipe.sv
// tb_mips_memory_stage_pipe: scoreboard bench with a byte-array memory model.
module tb_mips_memory_stage_pipe;
    localparam int ADDR_L = 64;
    localparam int NB = ADDR_L * 4;
    localparam logic [3:0] LB = 4'b0000, LBU = 4'b0001, LH = 4'b0010, LHU = 4'b0011, LW = 4'b0100;
    localparam logic [3:0] SB = 4'b1000, SH = 4'b1010, SW = 4'b1100;

    logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, out_is_load, out_fault;
    logic [31:0] in_addr = 0, in_data = 0, out_data;
    logic [3:0] in_op = 0;
    logic [4:0] in_rd = 0, out_rd;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        ld;
        logic        f;
    } exp_t;

    exp_t q[$];
    logic [7:0] mem [NB];
    int checks = 0, errors = 0;
    bit autoReady = 0;

    always #5 clk = ~clk;

    mips_memory_stage_pipe #(.ADDR_L(ADDR_L), .DATA_W(32)) dut (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_op(in_op), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_is_load(out_is_load), .out_fault(out_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit isFault(input logic [3:0] op, input logic [31:0] a);
`ifdef MIPS_MEMORY_MISALIGN_TRAP_EN
        return op[2:1] == 2'b11 || (op[2:1] == 2'b01 && a[0]) || (op[2:1] == 2'b10 && a[1:0] != 0);
`else
        return op[2:1] == 2'b11;
`endif
    endfunction

    // Byte-level reference: n-byte access at the naturally aligned base inside a wrapping byte space.
    task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data, output exp_t e);
        int a, n, base;
        logic [31:0] v;
        a = int'(addr & (NB - 1));
        n = op[2:1] == 2'b00 ? 1 : op[2:1] == 2'b01 ? 2 : 4;
        base = a & ~(n - 1);
        v = 0;
        e.f = isFault(op, addr);
        e.ld = !op[3] && !e.f;
        if (!e.f) begin
            for (int i = 0; i < n; i++)
                if (op[3]) mem[base + i] = data[8*i +: 8];
                else v[8*i +: 8] = mem[base + i];
            if (!op[3] && !op[0] && n < 4 && v[8*n-1]) v |= 32'hFFFFFFFF << (8 * n);
        end
        e.d = e.ld ? v : 32'h0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input bit useExp = 0, input logic [31:0] expD = 0);
        exp_t e;
        int n = 0;
        in_valid = 1; in_op = op; in_addr = addr; in_data = data; in_rd = rd;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout: in_ready got 0 want 1 op=%h addr=%h", op, addr);
            in_valid = 0;
            return;
        end
        model(op, addr, data, e);
        e.rd = rd;
        if (useExp) e.d = expD;
        q.push_back(e);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending got %0d want 0", q.size());
            q.delete();
        end
        #1;
    endtask

    always @(posedge clk) if (autoReady) #1 out_ready = $urandom_range(0, 3) != 0;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: out_valid got 1 want 0 rd=%0d", out_rd);
            end else begin
                chk("out_data", out_data, q[0].d);
                chk("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
                chk("out_is_load", {31'b0, out_is_load}, {31'b0, q[0].ld});
                chk("out_fault", {31'b0, out_fault}, {31'b0, q[0].f});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_rd", {27'b0, out_rd}, 0);
        chk("rst_out_is_load", {31'b0, out_is_load}, 0);
        chk("rst_out_fault", {31'b0, out_fault}, 0);
        rst = 0;
        out_ready = 1;
        for (int w = 0; w < ADDR_L; w++) issue(SW, 32'(w * 4), $urandom, 5'(w));

        issue(SW, 32'h10, 32'h8899AABB, 1);
        issue(LW, 32'h10, 0, 2, 1, 32'h8899AABB);
        issue(SB, 32'h13, 32'h80, 3);
        issue(LB, 32'h13, 0, 4, 1, 32'hFFFFFF80);
        issue(LBU, 32'h13, 0, 5, 1, 32'h00000080);
        issue(LH, 32'h12, 0, 6, 1, 32'hFFFF8099);
        issue(SW, 32'h100, 32'h1, 7);
        issue(LW, 32'h0, 0, 8, 1, 32'h1);
        issue(LH, 32'h11, 0, 9);
        issue(LHU, 32'h11, 0, 10);
        issue(SH, 32'h11, 32'hCAFE, 11);
        issue(4'b0110, 32'h10, 0, 12);
        issue(4'b1110, 32'h10, 32'hFFFFFFFF, 13);
        issue(LW, 32'h10, 0, 14);
        drain();

        autoReady = 0;
        out_ready = 0;
        issue(SW, 32'h20, 32'hDEADBEEF, 15);
        out_ready = 1;
        issue(LW, 32'h20, 0, 16);
        out_ready = 0;
        fork
            issue(SW, 32'h20, 32'h12345678, 17);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("in_ready_hold", {31'b0, in_ready}, 0);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        issue(LW, 32'h20, 0, 18, 1, 32'h12345678);
        drain();

        out_ready = 0;
        issue(LW, 32'h20, 0, 19);
        @(negedge clk);
        chk("hold_out_valid", {31'b0, out_valid}, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 0);
        chk("async_rst_out_fault", {31'b0, out_fault}, 0);
        chk("async_rst_out_data", out_data, 0);
        q.delete();
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        issue(LW, 32'h20, 0, 20, 1, 32'h12345678);
        drain();

        autoReady = 1;
        repeat (400) begin
            issue(4'($urandom), 32'($urandom_range(0, 511)), $urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        autoReady = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
